// File: rtl/serial_subtractor_4bit.sv
// Bit-serial D = A - B - B_in, LSB first; accept-to-result latency WIDTH+1 cycles.
// No backpressure: start is taken only in IDLE/DONE and is dropped while busy.
module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             B_out,
    output logic             V,
    output logic             Z
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   opa_q, opb_q, res_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               br_q;
    logic               a_msb_q, b_msb_q;
    logic [WIDTH-1:0]   d_q;
    logic               bout_q, v_q, z_q;

    logic               a_bit, b_bit, d_bit, br_next;
    logic [WIDTH-1:0]   res_next;
    logic               load, last;

    assign a_bit    = opa_q[0];
    assign b_bit    = opb_q[0];
    assign d_bit    = a_bit ^ b_bit ^ br_q;
    assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    assign res_next = {d_bit, res_q[WIDTH-1:1]};
    assign load     = (state_q != SHIFT) && start;
    assign last     = (state_q == SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last)  state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else if (load) begin
            opa_q   <= A;
            opb_q   <= B;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= B_in;
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
        end else if (state_q == SHIFT) begin
            opa_q <= opa_q >> 1;
            opb_q <= opb_q >> 1;
            res_q <= res_next;
            br_q  <= br_next;
            cnt_q <= cnt_q + 1'b1;
            // Visible results change only on the edge that enters DONE.
            if (last) begin
                d_q    <= res_next;
                bout_q <= br_next;
                v_q    <= (a_msb_q != b_msb_q) && (res_next[WIDTH-1] != a_msb_q);
                z_q    <= (res_next == '0);
            end
        end
    end

    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign D     = d_q;
    assign B_out = bout_q;
    assign V     = v_q;
    assign Z     = z_q;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Randomized and directed bench for serial_subtractor_4bit against an arithmetic model.
module tb_serial_subtractor_4bit;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_r = 1'b0;
    logic [W-1:0] a_r = '0;
    logic [W-1:0] b_r = '0;
    logic         bin_r = 1'b0;
    logic         busy, done, b_out, v, z;
    logic [W-1:0] d;

    int n_chk = 0;
    int n_err = 0;
    logic [W-1:0] last_d = '0;

    serial_subtractor_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_r),
        .A     (a_r),
        .B     (b_r),
        .B_in  (bin_r),
        .busy  (busy),
        .done  (done),
        .D     (d),
        .B_out (b_out),
        .V     (v),
        .Z     (z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {Z, V, B_out, D}. V follows the sign rule on the operands as captured.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic bin);
        int diff, sa, sb, sd;
        logic [W-1:0] dd;
        logic bo, vv, zz;
        diff = int'(a) - int'(b) - int'(bin);
        dd   = W'(diff & ((1 << W) - 1));
        bo   = (diff < 0);
        sa   = (int'(a) >= (1 << (W - 1))) ? int'(a) - (1 << W) : int'(a);
        sb   = (int'(b) >= (1 << (W - 1))) ? int'(b) - (1 << W) : int'(b);
        sd   = (int'(dd) >= (1 << (W - 1))) ? int'(dd) - (1 << W) : int'(dd);
        vv   = ((sa < 0) != (sb < 0)) && ((sd < 0) != (sa < 0));
        zz   = (dd == '0);
        return {zz, vv, bo, dd};
    endfunction

    // Launch one operation, wait for done (bounded), return the results.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input logic hold, input logic jitter,
                         output logic [W+2:0] res);
        int cyc;
        bit seen;
        a_r = a; b_r = b; bin_r = bin; start_r = 1'b1;
        @(posedge clk);
        #1;
        start_r = hold;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("D_held_on_accept", 32'(d), 32'(last_d));
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
            end else begin
                if (busy) cyc++;
                else cyc = 20;
                if (jitter) begin
                    a_r = W'($urandom); b_r = W'($urandom);
                    bin_r = 1'($urandom); start_r = 1'($urandom);
                end
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(cyc), 32'(W));
        res = {z, v, b_out, d};
        last_d = d;
        start_r = 1'b0;
    endtask

    task automatic op_vs_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                               input logic hold, input logic jitter);
        logic [W+2:0] res, exp;
        exp = model(a, b, bin);
        do_op(a, b, bin, hold, jitter, res);
        check("result_vs_model", 32'(res), 32'(exp));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [W+2:0] res;
        logic [W-1:0] ra, rb, s;
        logic [W-1:0] dir_a [6]  = '{4'b1011, 4'b0101, 4'b1001, 4'b1111, 4'b0000, 4'b0111};
        logic [W-1:0] dir_b [6]  = '{4'b1101, 4'b0011, 4'b0110, 4'b1111, 4'b0001, 4'b1000};
        logic         dir_bi[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        // {Z, V, B_out, D}
        logic [W+2:0] dir_e [6]  = '{7'b0_0_1_1110, 7'b0_0_0_0010, 7'b0_1_0_0010,
                                     7'b1_0_0_0000, 7'b0_0_1_1111, 7'b0_1_1_1111};

        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_outs", 32'({d, b_out, v, z}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, start held high across back-to-back operations.
        for (int i = 0; i < 6; i++) begin
            do_op(dir_a[i], dir_b[i], dir_bi[i], 1'b1, 1'b0, res);
            check($sformatf("directed_%0d", i), 32'(res), 32'(dir_e[i]));
        end

        // Single pulse: no further done or busy afterwards.
        op_vs_model(4'b0110, 4'b0010, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_extra_done", 32'(done), 32'd0);
            check("idle_not_busy", 32'(busy), 32'd0);
        end

        // Inputs and start toggled while shifting must not affect the result.
        for (int i = 0; i < 40; i++) begin
            op_vs_model(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end

        for (int i = 0; i < 512; i++) begin
            op_vs_model(W'(i >> 5), W'(i >> 1), 1'(i), 1'b1, 1'b0);
        end

        // Adder round trip: (A + B) - B returns A.
        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            s  = W'(int'(ra) + int'(rb));
            do_op(s, rb, 1'b0, 1'b0, 1'b0, res);
            check("round_trip", 32'(res[W-1:0]), 32'(ra));
        end

        // Abort mid-operation with reset.
        @(negedge clk);
        a_r = 4'b1010; b_r = 4'b0011; bin_r = 1'b1; start_r = 1'b1;
        @(posedge clk);
        #1 start_r = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_outs", 32'({done, d, b_out, v, z}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_abort_done", 32'(done), 32'd0);
            check("post_abort_state", 32'({busy, d, b_out, v, z}), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
